// File: rtl/pwm_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_cfg_pkg
//  Purpose  : Shared constants, command layout and FSM state encoding for the
//             PWM configuration controller.
//  Revision : 1.0  initial release
// ============================================================================
package pwm_cfg_pkg;

    // Register map (command bits 3:0)
    localparam logic [3:0] ADDR_PERIOD   = 4'd0;
    localparam logic [3:0] ADDR_PRESCALE = 4'd1;
    localparam logic [3:0] ADDR_DUTY1    = 4'd2;
    localparam logic [3:0] ADDR_DUTY2    = 4'd3;
    localparam logic [3:0] ADDR_DUTY3    = 4'd4;
    localparam logic [3:0] ADDR_CONTROL  = 4'd5;
    localparam logic [3:0] ADDR_STATUS   = 4'd6;

    // Number of shadowed configuration registers (addresses 0..4)
    localparam int NUM_CFG = 5;

    // Command byte layout
    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_ADDR_MSB = 3;
    localparam int CMD_ADDR_LSB = 0;

    // Control register bits
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FORCE_BIT = 1;

    // Status register bits
    localparam int STAT_PEND_BIT = 0;
    localparam int STAT_EN_BIT   = 1;
    localparam int STAT_ERR_BIT  = 2;

    // Frame FSM
    typedef enum logic [1:0] {
        ST_CMD  = 2'd0,
        ST_DATA = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for addresses that land in a shadow register
    function automatic logic is_cfg_addr(input logic [3:0] addr);
        return (addr <= ADDR_DUTY3);
    endfunction

endpackage : pwm_cfg_pkg
`default_nettype wire

// File: rtl/pwm_cfg_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_cfg_shifter
//  Purpose  : RX byte assembler (MSB first) and TX byte serializer with the
//             per-frame byte counter.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_cfg_shifter #(
    parameter int DATA_W = 32,
    parameter int NBYTES = DATA_W / 8,
    parameter int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cnt_clr,
    input  logic              rx_shift,
    input  logic [7:0]        rx_byte,
    input  logic              tx_load,
    input  logic [DATA_W-1:0] tx_load_word,
    input  logic              tx_shift,
    output logic [DATA_W-1:0] rx_word,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic              last_byte,
    output logic [7:0]        tx_next_byte
);

    // Only the already-received upper bytes need storage; the newest byte
    // comes straight from rx_byte so the word is complete on the last rx_dv.
    logic [DATA_W-9:0] rx_asm_q, rx_asm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Bytes still to be sent after the one currently being presented
    logic [DATA_W-9:0] tx_sr_q, tx_sr_d;

    assign rx_word      = {rx_asm_q, rx_byte};
    assign byte_cnt     = cnt_q;
    assign last_byte    = (cnt_q == CNT_W'(NBYTES - 1));
    assign tx_next_byte = tx_load ? tx_load_word[DATA_W-1 -: 8]
                                  : tx_sr_q[DATA_W-9 -: 8];

    // Next-state for assembler, counter and serializer
    always_comb begin
        rx_asm_d = rx_asm_q;
        cnt_d    = cnt_q;
        tx_sr_d  = tx_sr_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (rx_shift) begin
            rx_asm_d = rx_word[DATA_W-9:0];
            cnt_d    = cnt_q + CNT_W'(1);
        end
        if (tx_load) begin
            tx_sr_d = tx_load_word[DATA_W-9:0];
        end else if (tx_shift) begin
            tx_sr_d = {tx_sr_q[DATA_W-17:0], 8'h00};
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_asm_q <= '0;
            cnt_q    <= '0;
            tx_sr_q  <= '0;
        end else begin
            rx_asm_q <= rx_asm_d;
            cnt_q    <= cnt_d;
            tx_sr_q  <= tx_sr_d;
        end
    end

endmodule : pwm_cfg_shifter
`default_nettype wire

// File: rtl/pwm_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_cfg_ctrl
//  Purpose  : SPI command decoder and shadowed configuration scheduler for a
//             3-channel PWM. Shadow registers are committed atomically at the
//             PWM period boundary (or immediately when the PWM is disabled or
//             a force-commit is requested).
//  Options  : PWM_CFG_READBACK_EN - enables register read-back on the TX path
//             and status-read clearing of the sticky error flag.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_cfg_ctrl
    import pwm_cfg_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter logic [DATA_W-1:0] RST_PERIOD   = DATA_W'(255),
    parameter logic [DATA_W-1:0] RST_PRESCALE = DATA_W'(0)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_dv,
    input  logic [7:0]        rx_byte,
    input  logic              cs_n,
    input  logic              period_end,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    output logic [DATA_W-1:0] counter_value,
    output logic [DATA_W-1:0] prescaler,
    output logic [DATA_W-1:0] duty_cycle_1,
    output logic [DATA_W-1:0] duty_cycle_2,
    output logic [DATA_W-1:0] duty_cycle_3,
    output logic              enable_pwm
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    function automatic logic [DATA_W-1:0] cfg_rst_val(input int idx);
        if (idx == 0) return RST_PERIOD;
        if (idx == 1) return RST_PRESCALE;
        return '0;
    endfunction

    logic [1:0]        cs_sync_q, cs_sync_d;
    logic              cs_s;
    state_e            state_q, state_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [3:0]        cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] shadow_q [NUM_CFG];
    logic [DATA_W-1:0] shadow_d [NUM_CFG];
    logic [DATA_W-1:0] active_q [NUM_CFG];
    logic [DATA_W-1:0] active_d [NUM_CFG];
    logic              pending_q, pending_d;
    logic              err_q, err_d;
    logic              enable_q, enable_d;

    logic              sh_cnt_clr, sh_rx_shift, sh_tx_load, sh_tx_shift;
    logic [DATA_W-1:0] sh_load_word, sh_rx_word;
    logic [CNT_W-1:0]  sh_cnt;
    logic              sh_last;
    logic [7:0]        sh_tx_next;

    logic              err_set, err_clr, force_commit, shadow_wr;
    logic              tx_dv_d;
    logic [7:0]        tx_byte_d;
    logic [3:0]        rx_addr;

    assign cs_s    = cs_sync_q[1];
    assign rx_addr = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];

    assign counter_value = active_q[0];
    assign prescaler     = active_q[1];
    assign duty_cycle_1  = active_q[2];
    assign duty_cycle_2  = active_q[3];
    assign duty_cycle_3  = active_q[4];
    assign enable_pwm    = enable_q;

    // Reserved command bits carry no meaning
    logic unused_rsvd;
    assign unused_rsvd = ^rx_byte[6:4];

    pwm_cfg_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk          (clk),
        .rst_n        (rst_n),
        .cnt_clr      (sh_cnt_clr),
        .rx_shift     (sh_rx_shift),
        .rx_byte      (rx_byte),
        .tx_load      (sh_tx_load),
        .tx_load_word (sh_load_word),
        .tx_shift     (sh_tx_shift),
        .rx_word      (sh_rx_word),
        .byte_cnt     (sh_cnt),
        .last_byte    (sh_last),
        .tx_next_byte (sh_tx_next)
    );

`ifdef PWM_CFG_READBACK_EN
    logic [DATA_W-1:0] rd_word;
    logic              rd_invalid;
    logic              tx_dv_q;
    logic [7:0]        tx_byte_q;

    assign tx_dv   = tx_dv_q;
    assign tx_byte = tx_byte_q;

    // Read-back word for the address in the incoming command byte
    always_comb begin
        rd_word    = '0;
        rd_invalid = 1'b0;
        if (is_cfg_addr(rx_addr)) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (rx_addr == 4'(i)) rd_word = active_q[i];
            end
        end else if (rx_addr == ADDR_CONTROL) begin
            rd_word[CTRL_EN_BIT] = enable_q;
        end else if (rx_addr == ADDR_STATUS) begin
            rd_word[STAT_PEND_BIT] = pending_q;
            rd_word[STAT_EN_BIT]   = enable_q;
            rd_word[STAT_ERR_BIT]  = err_q;
        end else begin
            rd_invalid = 1'b1;
        end
    end

    // TX output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
        end
    end
`else
    assign tx_dv   = 1'b0;
    assign tx_byte = 8'h00;

    // Without read-back the serializer, byte index, TX-next mux and err
    // flag have no observer.
    logic unused_rb;
    assign unused_rb = ^{sh_tx_next, sh_cnt, err_q, tx_dv_d, tx_byte_d};
`endif

    // Frame FSM, write decode, commit scheduling and read-back sequencing
    always_comb begin
        cs_sync_d    = {cs_sync_q[0], cs_n};
        state_d      = state_q;
        cmd_wr_d     = cmd_wr_q;
        cmd_addr_d   = cmd_addr_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        err_d        = err_q;
        enable_d     = enable_q;
        sh_cnt_clr   = 1'b0;
        sh_rx_shift  = 1'b0;
        sh_tx_load   = 1'b0;
        sh_tx_shift  = 1'b0;
        sh_load_word = '0;
        err_set      = 1'b0;
        err_clr      = 1'b0;
        force_commit = 1'b0;
        shadow_wr    = 1'b0;
        tx_dv_d      = 1'b0;
        tx_byte_d    = tx_byte;

        if (cs_s) begin
            // Deselected: abandon any partial frame
            state_d = ST_CMD;
        end else begin
            case (state_q)
                ST_CMD: begin
                    if (rx_dv) begin
                        cmd_wr_d   = rx_byte[CMD_WR_BIT];
                        cmd_addr_d = rx_addr;
                        sh_cnt_clr = 1'b1;
                        state_d    = ST_DATA;
`ifdef PWM_CFG_READBACK_EN
                        if (!rx_byte[CMD_WR_BIT]) begin
                            sh_tx_load   = 1'b1;
                            sh_load_word = rd_word;
                            tx_dv_d      = 1'b1;
                            tx_byte_d    = sh_tx_next;
                            err_set      = rd_invalid;
                        end
`endif
                    end
                end
                ST_DATA: begin
                    if (rx_dv) begin
                        sh_rx_shift = 1'b1;
                        if (sh_last) state_d = ST_DONE;
                        if (cmd_wr_q && sh_last) begin
                            if (is_cfg_addr(cmd_addr_q)) begin
                                for (int i = 0; i < NUM_CFG; i++) begin
                                    if (cmd_addr_q == 4'(i)) shadow_d[i] = sh_rx_word;
                                end
                                shadow_wr = 1'b1;
                            end else if (cmd_addr_q == ADDR_CONTROL) begin
                                enable_d     = sh_rx_word[CTRL_EN_BIT];
                                force_commit = sh_rx_word[CTRL_FORCE_BIT];
                            end else begin
                                err_set = 1'b1;
                            end
                        end
`ifdef PWM_CFG_READBACK_EN
                        if (!cmd_wr_q && !sh_last) begin
                            sh_tx_shift = 1'b1;
                            tx_dv_d     = 1'b1;
                            tx_byte_d   = sh_tx_next;
                            // This load presents byte0 of the word
                            if (sh_cnt == CNT_W'(NBYTES - 2) && cmd_addr_q == ADDR_STATUS)
                                err_clr = 1'b1;
                        end
`endif
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_CMD;
                end
            endcase
        end

        // Commit takes the pre-write shadows; a write landing this cycle
        // keeps pending set for the next boundary.
        if (pending_q && (period_end || !enable_q || force_commit)) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (shadow_wr) pending_d = 1'b1;

        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    // Control-path and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q  <= 2'b11;
            state_q    <= ST_CMD;
            cmd_wr_q   <= 1'b0;
            cmd_addr_q <= 4'h0;
            for (int i = 0; i < NUM_CFG; i++) begin
                shadow_q[i] <= cfg_rst_val(i);
                active_q[i] <= cfg_rst_val(i);
            end
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            enable_q   <= 1'b0;
        end else begin
            cs_sync_q  <= cs_sync_d;
            state_q    <= state_d;
            cmd_wr_q   <= cmd_wr_d;
            cmd_addr_q <= cmd_addr_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            err_q      <= err_d;
            enable_q   <= enable_d;
        end
    end

endmodule : pwm_cfg_ctrl
`default_nettype wire

// File: tb/tb_pwm_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_cfg_ctrl
//  Purpose  : Scoreboard bench for pwm_cfg_ctrl. Expected TX bytes and
//             expected configuration snapshots are queued as stimulus is
//             issued; a monitor compares whenever tx_dv pulses or the active
//             configuration changes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_cfg_ctrl;

    typedef struct packed {
        logic [31:0] cv;
        logic [31:0] ps;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
        logic        en;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        cs_n = 1'b1;
    logic        period_end = 1'b0;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic [31:0] counter_value, prescaler, duty_cycle_1, duty_cycle_2, duty_cycle_3;
    logic        enable_pwm;

    int errors = 0;
    int checks = 0;

    logic [7:0] tx_q [$];
    cfg_t       cfg_q [$];
    cfg_t       exp_cfg, last_cfg, rst_cfg, mon_cur, mon_exp;
    logic [7:0] mon_b;

    pwm_cfg_ctrl #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_dv         (rx_dv),
        .rx_byte       (rx_byte),
        .cs_n          (cs_n),
        .period_end    (period_end),
        .tx_dv         (tx_dv),
        .tx_byte       (tx_byte),
        .counter_value (counter_value),
        .prescaler     (prescaler),
        .duty_cycle_1  (duty_cycle_1),
        .duty_cycle_2  (duty_cycle_2),
        .duty_cycle_3  (duty_cycle_3),
        .enable_pwm    (enable_pwm)
    );

    always #5 clk = ~clk;

    // Monitor: compare on every TX pulse and every active-config change
    always @(negedge clk) begin
        if (tx_dv === 1'b1) begin
            checks++;
            if (tx_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got %02h, nothing expected", tx_byte);
            end else begin
                mon_b = tx_q.pop_front();
                if (tx_byte !== mon_b) begin
                    errors++;
                    $display("FAIL tx_byte: got %02h, expected %02h", tx_byte, mon_b);
                end
            end
        end
        mon_cur = '{counter_value, prescaler, duty_cycle_1, duty_cycle_2, duty_cycle_3, enable_pwm};
        if (mon_cur !== last_cfg) begin
            checks++;
            if (cfg_q.size() == 0) begin
                errors++;
                $display("FAIL cfg_unexpected: got %h, was %h", mon_cur, last_cfg);
            end else begin
                mon_exp = cfg_q.pop_front();
                if (mon_cur !== mon_exp) begin
                    errors++;
                    $display("FAIL cfg_change: got %h, expected %h", mon_cur, mon_exp);
                end
            end
            last_cfg = mon_cur;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic pe);
        repeat (2) @(posedge clk);
        #1;
        rx_dv      = 1'b1;
        rx_byte    = b;
        period_end = pe;
        @(posedge clk);
        #1;
        rx_dv      = 1'b0;
        period_end = 1'b0;
    endtask

    task automatic cs_low();
        @(posedge clk);
        #1 cs_n = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic cs_high();
        repeat (2) @(posedge clk);
        #1 cs_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic pulse_pe();
        @(posedge clk);
        #1 period_end = 1'b1;
        @(posedge clk);
        #1 period_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic frame_wr(input logic [3:0] addr, input logic [31:0] data, input logic pe_last);
        cs_low();
        send({4'h8, addr}, 1'b0);
        for (int i = 3; i >= 0; i--) send(data[i*8 +: 8], (i == 0) ? pe_last : 1'b0);
        cs_high();
    endtask

    task automatic frame_rd(input logic [3:0] addr, input logic [31:0] exp_word);
`ifdef PWM_CFG_READBACK_EN
        for (int i = 3; i >= 0; i--) tx_q.push_back(exp_word[i*8 +: 8]);
`else
        if (exp_word === 32'hxxxx_xxxx) $display("note: undefined expected word");
`endif
        cs_low();
        send({4'h0, addr}, 1'b0);
        for (int i = 0; i < 4; i++) send(8'hA5, 1'b0);
        cs_high();
    endtask

    initial begin
        rst_cfg  = '{32'd255, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0};
        exp_cfg  = rst_cfg;
        last_cfg = rst_cfg;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_counter", counter_value, 32'd255);
        check("rst_prescaler", prescaler, 32'd0);
        check("rst_duty1", duty_cycle_1, 32'd0);
        check("rst_duty3", duty_cycle_3, 32'd0);
        check("rst_enable", {31'd0, enable_pwm}, 32'd0);
        check("rst_tx", {23'd0, tx_dv, tx_byte}, 32'd0);

        // Read period after reset
        frame_rd(4'd0, 32'h0000_00FF);
        check("en_after_read", {31'd0, enable_pwm}, 32'd0);

        // Disabled PWM: duty1 write commits within two cycles
        exp_cfg.d1 = 32'h80;
        cfg_q.push_back(exp_cfg);
        cs_low();
        send(8'h82, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h80, 1'b0);
        @(posedge clk);
        #1;
        check("duty1_fast_commit", duty_cycle_1, 32'h80);
        cs_high();
        frame_rd(4'd6, 32'h0);

        // Enabled PWM: period held until the boundary
        exp_cfg.en = 1'b1;
        cfg_q.push_back(exp_cfg);
        frame_wr(4'd5, 32'h1, 1'b0);
        frame_wr(4'd0, 32'h3E8, 1'b0);
        frame_rd(4'd6, 32'h3);
        check("period_held", counter_value, 32'd255);
        exp_cfg.cv = 32'h3E8;
        cfg_q.push_back(exp_cfg);
        pulse_pe();
        check("period_commit", counter_value, 32'h3E8);

        // Last write byte coincident with period_end
        frame_wr(4'd3, 32'h55, 1'b0);
        exp_cfg.d2 = 32'h55;
        cfg_q.push_back(exp_cfg);
        frame_wr(4'd4, 32'h1234, 1'b1);
        check("duty2_boundary", duty_cycle_2, 32'h55);
        check("duty3_deferred", duty_cycle_3, 32'h0);
        exp_cfg.d3 = 32'h1234;
        cfg_q.push_back(exp_cfg);
        pulse_pe();
        check("duty3_next_boundary", duty_cycle_3, 32'h1234);

        // Aborted prescaler write, then a full one
        cs_low();
        send(8'h81, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        cs_high();
        frame_rd(4'd6, 32'h2);
        pulse_pe();
        check("prescaler_abort", prescaler, 32'h0);
        exp_cfg.ps = 32'h7;
        cfg_q.push_back(exp_cfg);
        frame_wr(4'd1, 32'h7, 1'b0);
        pulse_pe();
        check("prescaler_full", prescaler, 32'h7);

        // Force-commit through the control register
        frame_wr(4'd2, 32'h99, 1'b0);
        exp_cfg.d1 = 32'h99;
        cfg_q.push_back(exp_cfg);
        frame_wr(4'd5, 32'h3, 1'b0);
        check("force_commit", duty_cycle_1, 32'h99);

        // Error flag: invalid write and invalid read
        exp_cfg.en = 1'b0;
        cfg_q.push_back(exp_cfg);
        frame_wr(4'd5, 32'h0, 1'b0);
        frame_wr(4'd9, 32'hDEAD_BEEF, 1'b0);
        frame_rd(4'd6, 32'h4);
        frame_rd(4'd6, 32'h0);
        frame_rd(4'd12, 32'h0);
        frame_rd(4'd6, 32'h4);
        frame_rd(4'd6, 32'h0);

        // Reset in the middle of a frame
        cs_low();
        send(8'h82, 1'b0);
        send(8'h11, 1'b0);
        exp_cfg = rst_cfg;
        cfg_q.push_back(exp_cfg);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_counter", counter_value, 32'd255);
        check("midrst_duty3", duty_cycle_3, 32'd0);
        cs_n = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        exp_cfg.d1 = 32'h42;
        cfg_q.push_back(exp_cfg);
        frame_wr(4'd2, 32'h42, 1'b0);
        check("post_rst_write", duty_cycle_1, 32'h42);

        repeat (10) @(posedge clk);
        #1;
        check("tx_queue_drained", tx_q.size(), 32'd0);
        check("cfg_queue_drained", cfg_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pwm_cfg_ctrl
`default_nettype wire

// File: doc/pwm_cfg_ctrl.md
Name: pwm_cfg_ctrl

Overview:
- Command decoder and configuration scheduler between the SPI slave byte interface and the 3-channel PWM datapath.
- Parses framed SPI command bytes and assembles 32-bit register writes into shadow registers.
- Commits shadows to the PWM configuration outputs atomically at the PWM period boundary, so the PWM never runs a torn configuration.
- Serves register read-back to the SPI slave TX path.

Parameters:
- DATA_W, 32, width of each PWM configuration register; bytes per transfer = DATA_W/8.
- RST_PERIOD, 32'd255, reset value of counter_value.
- RST_PRESCALE, 32'd0, reset value of prescaler.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_dv  in  1  one-cycle pulse; rx_byte valid.
- rx_byte  in  8  byte received on MOSI.
- cs_n  in  1  SPI chip select, raw pin, asynchronous; synchronised internally with 2 flops.
- period_end  in  1  one-cycle pulse from the PWM at counter wrap.
- tx_dv  out  1  one-cycle pulse loading tx_byte into the SPI slave.
- tx_byte  out  8  next MISO byte.
- counter_value, prescaler, duty_cycle_1, duty_cycle_2, duty_cycle_3  out  DATA_W  active PWM configuration.
- enable_pwm  out  1  PWM run enable.

Behaviour:
- Reset values (async, rst_n low):
  - counter_value = RST_PERIOD; prescaler = RST_PRESCALE.
  - duties = 0; enable_pwm = 0; tx_dv = 0; tx_byte = 0.
  - all shadows equal the active values; pending = 0; err = 0; FSM in CMD.
- Command byte format:
  - bit7 = write(1)/read(0); bits6:4 reserved, ignored.
  - bits3:0 = address: 0 period, 1 prescaler, 2 duty1, 3 duty2, 4 duty3, 5 control, 6 status (RO).
- Frame: starts on the synchronised cs_n falling edge; the FSM is forced to CMD whenever synchronised cs_n = 1.
- FSM states:
  - CMD: on rx_dv, latch command, clear byte count, go to DATA.
  - DATA: each rx_dv shifts rx_byte into the assembler, MSB first. On the 4th byte, perform the write, then go to DONE.
  - DONE: further rx_dv ignored until cs_n rises.
- Writes to addr 0-4: update the shadow register and set pending. No change to the active output yet.
- Writes to addr 5 (unshadowed):
  - bit0 drives enable_pwm the next cycle.
  - bit1 = force-commit request, executed the same cycle as the write.
- Writes to addr 6 or 7-15: discarded, and sticky err is set.
- Commit: copy all shadows to the active outputs and clear pending in one cycle when pending and any of:
  - period_end = 1;
  - enable_pwm = 0;
  - force-commit.
- Simultaneous events:
  - 4th write byte and period_end in the same cycle: the commit uses the pre-write shadows; the new value stays pending until the next boundary.
  - Commit and a new shadow write in the same cycle: pending stays 1.
- Read, addr 0-5: the cycle after the command byte's rx_dv, pulse tx_dv with byte3 of the active (not shadow) value. The cycle after each following rx_dv, pulse tx_dv with the next lower byte; stop after byte0.
- Read, addr 6 (status): bit0 pending, bit1 enable_pwm, bit2 err, other bits 0. The read clears err when its byte0 is loaded.
- Read, invalid addr: returns 0x00 bytes and sets err.
- cs_n rising mid-transfer: the partial word is dropped; no shadow or pending change.
- Reset mid-frame: everything returns to reset values immediately.

Optional Feature:
- Macro: PWM_CFG_READBACK_EN.
- Defined: read commands behave as above.
- Undefined:
  - tx_dv is tied 0 and tx_byte is tied 0; read commands consume their bytes with no effect.
  - status-read clearing of err is absent; err clears only on reset.

Decomposition:
- Package pwm_cfg_pkg:
  - address localparams (ADDR_PERIOD..ADDR_STATUS);
  - command bit positions (CMD_WR_BIT, CMD_ADDR_MSB/LSB);
  - FSM state enum (ST_CMD, ST_DATA, ST_DONE);
  - control/status bit indices.
- One sub-module, pwm_cfg_shifter: 32-bit byte assembler for RX plus byte serializer for TX, with a 2-bit byte counter. The top holds the FSM, shadows and commit logic.

Test Plan:
- Reset, then read addr 0 -> tx bytes 00 00 00 FF; enable_pwm = 0.
- enable_pwm = 0; write addr 2 = 0x00000080 -> duty_cycle_1 = 0x80 within 2 cycles of the 4th rx_dv; pending back to 0.
- Write control = 0x01, then period = 0x000003E8 -> counter_value unchanged until the first period_end pulse, then 0x3E8; status read before the pulse = 0x03.
- 4th byte of a duty3 write coincident with period_end -> duty_cycle_3 unchanged that boundary; updated at the next period_end.
- cs_n raised after 2 data bytes of a prescaler write -> prescaler and pending unchanged; the next full frame decodes correctly.
- Write addr 9, then read status -> byte0 = 0x04 (err set); second status read -> 0x00.
